// File: rtl/alu_seq_core.sv
// -----------------------------------------------------------------------------
// alu_seq_core
//   Handshaked accumulator ALU with WIDTH-bit operands. Single-cycle ops are
//   registered on the accept edge; MUL (shift-add) and DIV (restoring) run
//   iteratively for WIDTH cycles. A request tag travels with every op.
//
// Configuration macro: ALU_SEQ_DIV_EN
//   defined   : iterative restoring divider present (op 6).
//   undefined : divider removed; op 6 completes in one cycle with
//               des1 = 0, des2 = 0, Cy = 0, Ov = 1, Ac = srcAc.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake
//   op_code, src1/src2  operation and operands
//   srcCy, srcAc        PSW carry / aux carry in
//   tag_in / tag_out    request tag in, tag of the result held in des1/des2
//   out_valid/out_ready result handshake; fields stable while stalled
//   des1, des2          primary / secondary result
//   desCy, desAc, desOv result flags
//   busy                iterative op in progress
// -----------------------------------------------------------------------------

module alu_seq_core_chk (
  input logic       clk,
  input logic       rst,
  input logic       accept_i,
  input logic [3:0] op_code_i
);
  // An accepted request must carry a fully defined operation code.
  a_op_known: assert property (@(posedge clk) disable iff (!rst)
    accept_i |-> !$isunknown(op_code_i))
    else $error("alu_seq_core: undefined op_code on accept edge");
endmodule

module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             srcCy,
  input  logic             srcAc,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] des1,
  output logic [WIDTH-1:0] des2,
  output logic             desCy,
  output logic             desAc,
  output logic             desOv,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h0, OP_ADDC = 4'h1, OP_SUBB = 4'h2, OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4, OP_MUL  = 4'h5, OP_DIV  = 4'h6, OP_AND = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8, OP_XOR  = 4'h9, OP_CPL  = 4'hA, OP_RL  = 4'hB;
  localparam logic [3:0] OP_RLC  = 4'hC, OP_RR   = 4'hD, OP_RRC  = 4'hE, OP_CMP = 4'hF;

  typedef enum logic {ST_IDLE = 1'b0, ST_ITER = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d, busy_q, busy_d;
  logic [WIDTH-1:0] des1_q, des1_d, des2_q, des2_d;
  logic             cy_q, cy_d, ac_q, ac_d, ov_q, ov_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  // Iterative unit: hi = partial product / remainder, lo = multiplier / quotient.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
`ifdef ALU_SEQ_DIV_EN
  logic             is_mul_q, is_mul_d;
  logic [WIDTH:0]   div_rem_s;
  logic             div_ge_s;
`endif

  logic             accept_s, iter_op_s, sub_s, cin_s;
  logic [WIDTH-1:0] bx_s, r1_s, step_hi_s, step_lo_s;
  logic [WIDTH:0]   sum_s, mul_sum_s;
  logic             rcy_s, rac_s, rov_s;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
`ifdef ALU_SEQ_DIV_EN
  assign iter_op_s = (op_code == OP_MUL) || (op_code == OP_DIV);
`else
  assign iter_op_s = (op_code == OP_MUL);
`endif

  // Single-cycle ALU: shared adder for ADD/ADDC/SUBB/CMP plus logic and rotates.
  always_comb begin
    sub_s = (op_code == OP_SUBB) || (op_code == OP_CMP);
    bx_s  = sub_s ? ~src2 : src2;
    // Subtraction is a + ~b + ~borrow_in; carry outs are inverted into borrows.
    cin_s = (op_code == OP_ADD) ? 1'b0 : (sub_s ? ~srcCy : srcCy);
    sum_s = {1'b0, src1} + {1'b0, bx_s} + {{WIDTH{1'b0}}, cin_s};
    r1_s  = src1;
    rcy_s = srcCy;
    rac_s = srcAc;
    rov_s = 1'b0;
    case (op_code)
      OP_ADD, OP_ADDC, OP_SUBB, OP_CMP: begin
        r1_s  = (op_code == OP_CMP) ? src1 : sum_s[WIDTH-1:0];
        rcy_s = sum_s[WIDTH] ^ sub_s;
        // Carry out of bit 3 equals the carry into bit 4.
        rac_s = src1[4] ^ bx_s[4] ^ sum_s[4] ^ sub_s;
        rov_s = (src1[WIDTH-1] == bx_s[WIDTH-1]) && (sum_s[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_INC:  r1_s = src1 + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC:  r1_s = src1 - {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DIV: begin
        // Only reached when the divider is not built.
        r1_s  = {WIDTH{1'b0}};
        rcy_s = 1'b0;
        rov_s = 1'b1;
      end
      OP_AND:  r1_s = src1 & src2;
      OP_OR:   r1_s = src1 | src2;
      OP_XOR:  r1_s = src1 ^ src2;
      OP_CPL:  r1_s = ~src1;
      OP_RL:   r1_s = {src1[WIDTH-2:0], src1[WIDTH-1]};
      OP_RLC: begin
        r1_s  = {src1[WIDTH-2:0], srcCy};
        rcy_s = src1[WIDTH-1];
      end
      OP_RR:   r1_s = {src1[0], src1[WIDTH-1:1]};
      OP_RRC: begin
        r1_s  = {srcCy, src1[WIDTH-1:1]};
        rcy_s = src1[0];
      end
      default: r1_s = src1;
    endcase
  end

  // One shift-add (MUL) or restoring-subtract (DIV) step of the iterative unit.
  always_comb begin
    mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
`ifdef ALU_SEQ_DIV_EN
    div_rem_s = {hi_q, lo_q[WIDTH-1]};
    div_ge_s  = (div_rem_s >= {1'b0, b_q});
    if (is_mul_q) begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end else begin
      // Remainder after subtraction is below the divisor, so WIDTH bits suffice.
      // A zero divisor naturally yields quotient all-ones, remainder = dividend.
      step_hi_s = div_rem_s[WIDTH-1:0] - (div_ge_s ? b_q : {WIDTH{1'b0}});
      step_lo_s = {lo_q[WIDTH-2:0], div_ge_s};
    end
`else
    step_hi_s = mul_sum_s[WIDTH:1];
    step_lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
`endif
  end

  // Next-state logic for the control FSM, iterative unit and output register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    des1_d      = des1_q;
    des2_d      = des2_q;
    cy_d        = cy_q;
    ac_d        = ac_q;
    ov_d        = ov_q;
    tag_d       = tag_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
`ifdef ALU_SEQ_DIV_EN
    is_mul_d    = is_mul_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s && iter_op_s) begin
          // Output register is empty or draining this edge, so the tag and
          // fixed flags can be parked in it now; out_valid stays low.
          state_d     = ST_ITER;
          cnt_d       = CW'(WIDTH);
          busy_d      = 1'b1;
          out_valid_d = 1'b0;
          hi_d        = {WIDTH{1'b0}};
          lo_d        = src1;
          b_d         = src2;
          tag_d       = tag_in;
          cy_d        = 1'b0;
          ac_d        = srcAc;
          ov_d        = (src2 == {WIDTH{1'b0}});
`ifdef ALU_SEQ_DIV_EN
          is_mul_d    = (op_code == OP_MUL);
`endif
        end else if (accept_s) begin
          out_valid_d = 1'b1;
          des1_d      = r1_s;
          des2_d      = {WIDTH{1'b0}};
          cy_d        = rcy_s;
          ac_d        = rac_s;
          ov_d        = rov_s;
          tag_d       = tag_in;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q - CW'(1);
        hi_d  = step_hi_s;
        lo_d  = step_lo_s;
        if (cnt_q == CW'(1)) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          des1_d      = step_lo_s;
          des2_d      = step_hi_s;
`ifdef ALU_SEQ_DIV_EN
          ov_d        = is_mul_q ? (step_hi_s != {WIDTH{1'b0}}) : ov_q;
`else
          ov_d        = (step_hi_s != {WIDTH{1'b0}});
`endif
        end else begin
          state_d = ST_ITER;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight op and held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      des1_q      <= {WIDTH{1'b0}};
      des2_q      <= {WIDTH{1'b0}};
      cy_q        <= 1'b0;
      ac_q        <= 1'b0;
      ov_q        <= 1'b0;
      tag_q       <= {TAG_W{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
`ifdef ALU_SEQ_DIV_EN
      is_mul_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      des1_q      <= des1_d;
      des2_q      <= des2_d;
      cy_q        <= cy_d;
      ac_q        <= ac_d;
      ov_q        <= ov_d;
      tag_q       <= tag_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
`ifdef ALU_SEQ_DIV_EN
      is_mul_q    <= is_mul_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign des1      = des1_q;
  assign des2      = des2_q;
  assign desCy     = cy_q;
  assign desAc     = ac_q;
  assign desOv     = ov_q;
  assign tag_out   = tag_q;

  alu_seq_core_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .accept_i  (accept_s),
    .op_code_i (op_code)
  );
endmodule

// File: tb/tb_alu_seq_core.sv
module tb_alu_seq_core;
  logic       clk = 1'b0, rst = 1'b0;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [3:0] op_code = 4'h0, tag_in = 4'h0, tag_out;
  logic [7:0] src1 = 8'h00, src2 = 8'h00, des1, des2;
  logic       srcCy = 1'b0, srcAc = 1'b0, desCy, desAc, desOv;

  typedef struct {
    logic [3:0] op; logic [7:0] a, b; logic cy, ac;
    logic [7:0] e1, e2; logic ecy, eac, eov;
  } vec_t;
  typedef struct { logic [3:0] tag; logic [7:0] d1, d2; logic cy, ac, ov; } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  exp_t cur_e;
  int   n_chk = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_code(op_code),
    .src1(src1), .src2(src2), .srcCy(srcCy), .srcAc(srcAc), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .des1(des1), .des2(des2),
    .desCy(desCy), .desAc(desAc), .desOv(desOv), .tag_out(tag_out), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard: compare every delivered result with the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_result got tag=%0d des1=%h exp no result", tag_out, des1);
      end else begin
        cur_e = sb.pop_front();
        check($sformatf("result_tag%0d", cur_e.tag),
              {9'd0, tag_out, des1, des2, desCy, desAc, desOv},
              {9'd0, cur_e.tag, cur_e.d1, cur_e.d2, cur_e.cy, cur_e.ac, cur_e.ov});
      end
    end
  end

  // Drive a request, wait (bounded) for acceptance, push its expectation.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cy, input logic ac, input exp_t e);
    int n = 0;
    in_valid = 1'b1; op_code = op; src1 = a; src2 = b; srcCy = cy; srcAc = ac; tag_in = e.tag;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_bad++;
      $display("FAIL accept_timeout got in_ready=%b exp 1", in_ready);
      in_valid = 1'b0;
    end else begin
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout got pending=%0d exp 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op    a      b      cy    ac    e1     e2     ecy   eac   eov
    vq.push_back('{4'h0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1});
    vq.push_back('{4'h0, 8'h08, 8'h08, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
    vq.push_back('{4'h1, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1});
    vq.push_back('{4'h1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0});
    vq.push_back('{4'h2, 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0});
    vq.push_back('{4'h2, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1});
    vq.push_back('{4'h2, 8'h50, 8'h20, 1'b1, 1'b0, 8'h2F, 8'h00, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'hF, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0});
    vq.push_back('{4'hF, 8'h50, 8'h20, 1'b1, 1'b1, 8'h50, 8'h00, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'h3, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'h4, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'h5, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b1});
    vq.push_back('{4'h5, 8'h0C, 8'h0A, 1'b1, 1'b0, 8'h78, 8'h00, 1'b0, 1'b0, 1'b0});
`ifdef ALU_SEQ_DIV_EN
    vq.push_back('{4'h6, 8'hFB, 8'h12, 1'b1, 1'b1, 8'h0D, 8'h11, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'h6, 8'h55, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1});
`else
    vq.push_back('{4'h6, 8'hFB, 8'h12, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1});
    vq.push_back('{4'h6, 8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1});
`endif
    vq.push_back('{4'h7, 8'hF0, 8'h3C, 1'b1, 1'b1, 8'h30, 8'h00, 1'b1, 1'b1, 1'b0});
    vq.push_back('{4'h8, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'h9, 8'hAA, 8'hFF, 1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'hA, 8'h5A, 8'h00, 1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'hB, 8'h81, 8'h00, 1'b0, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hC, 8'h81, 8'h00, 1'b0, 1'b1, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0});
    vq.push_back('{4'hD, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'hE, 8'h03, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'hE, 8'h02, 8'h00, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {7'd0, out_valid, busy, des1, des2, tag_out, desCy, desAc, desOv}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Table: back-to-back issue with the consumer always ready
    foreach (vq[i])
      issue(vq[i].op, vq[i].a, vq[i].b, vq[i].cy, vq[i].ac,
            '{4'(i), vq[i].e1, vq[i].e2, vq[i].ecy, vq[i].eac, vq[i].eov});
    wait_drain();

    // MUL latency: busy and !in_ready for 8 cycles, result after the 8th
    issue(4'h5, 8'hFF, 8'hFF, 1'b1, 1'b0, '{4'hA, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 8; k++) begin
      check($sformatf("mul_iter_c%0d", k), {29'd0, busy, in_ready, out_valid}, 32'b100);
      @(posedge clk); #1;
    end
    check("mul_done", {29'd0, busy, in_ready, out_valid}, 32'b011);
    wait_drain();

    // DIV latency: iterative with the divider, single cycle without it
`ifdef ALU_SEQ_DIV_EN
    issue(4'h6, 8'h55, 8'h00, 1'b0, 1'b1, '{4'hB, 8'hFF, 8'h55, 1'b0, 1'b1, 1'b1});
    check("div_latency", {30'd0, busy, out_valid}, 32'b10);
`else
    issue(4'h6, 8'h55, 8'h00, 1'b0, 1'b1, '{4'hB, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1});
    check("div_latency", {30'd0, busy, out_valid}, 32'b01);
`endif
    wait_drain();

    // Backpressure: second request held, first result stable, then both in order
    out_ready = 1'b0;
    issue(4'h0, 8'h7F, 8'h01, 1'b0, 1'b0, '{4'h1, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1});
    in_valid = 1'b1; op_code = 4'h0; src1 = 8'h10; src2 = 8'h22; srcCy = 1'b0; srcAc = 1'b0;
    tag_in = 4'h2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold_c%0d", k), {18'd0, in_ready, out_valid, tag_out, des1},
            {18'd0, 1'b0, 1'b1, 4'h1, 8'h80});
      @(posedge clk); #1;
    end
    sb.push_back('{4'h2, 8'h32, 8'h00, 1'b0, 1'b0, 1'b0});
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second", {19'd0, out_valid, tag_out, des1}, {19'd0, 1'b1, 4'h2, 8'h32});
    wait_drain();

    // Reset during the 4th iteration cycle: op and result are discarded
`ifdef ALU_SEQ_DIV_EN
    in_valid = 1'b1; op_code = 4'h6; src1 = 8'hFB; src2 = 8'h12;
`else
    in_valid = 1'b1; op_code = 4'h5; src1 = 8'h0C; src2 = 8'h0A;
`endif
    tag_in = 4'h7;
    @(negedge clk);
    check("rst_op_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_op", {30'd0, out_valid, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("no_stale_c%0d", k), {30'd0, out_valid, busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
